// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes and FSM encoding for the convolution scan sequencer
package conv_pkg;
  localparam int KW = 3;
  localparam int OW = 19;
  localparam int NTAP = 16;
  localparam int KCW = 2;
  localparam int OCW = 5;
  localparam int AW = 4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/wrap_cnt.sv
// wrap_cnt: modulo-(MAX+1) counter with clear, enable and at-max flag
module wrap_cnt #(
  parameter int W = 2,
  parameter int MAX = 2
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_max
);
  assign at_max = q == W'(MAX);
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) q <= '0;
    else if (clear) q <= '0;
    else if (en) q <= at_max ? '0 : q + W'(1);
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: loads a kernel's weights, then scans kernel (x,y) inside
// output (X,Y) positions, emitting MAC-valid and weight-tile move pulses.
module conv_seq_ctrl import conv_pkg::*; #(
  parameter int KW = conv_pkg::KW,
  parameter int OW = conv_pkg::OW,
  parameter int NTAP = conv_pkg::NTAP
) (
  input  logic           clk,
  input  logic           xrst,
  input  logic           start,
  input  logic           stall,
  output logic [AW-1:0]  w_raddr,
  output logic           w_ren,
  output logic           w_load,
  output logic           shift_x,
  output logic           shift_y,
  output logic           ret,
  output logic [KCW-1:0] x,
  output logic [KCW-1:0] y,
  output logic [OCW-1:0] X,
  output logic [OCW-1:0] Y,
  output logic           valid,
  output logic           busy,
  output logic           finish
);
  state_t state;
  logic idle, adv, xm, ym, xxm, yym, last;
  assign idle = state == IDLE;
  assign adv = state == RUN && !stall;
  assign last = xm && ym && xxm && yym;
  assign valid = adv;
  assign shift_x = adv && !xm;
  assign shift_y = adv && xm && !ym;
  // the final window moves nowhere, so it gets no return pulse
  assign ret = adv && xm && ym && !(xxm && yym);
  assign busy = state == LOAD || state == RUN;
  assign finish = state == DONE;
  wrap_cnt #(.W(KCW), .MAX(KW-1)) u_x (.clk(clk), .xrst(xrst), .clear(idle), .en(adv), .q(x), .at_max(xm));
  wrap_cnt #(.W(KCW), .MAX(KW-1)) u_y (.clk(clk), .xrst(xrst), .clear(idle), .en(adv && xm), .q(y), .at_max(ym));
  wrap_cnt #(.W(OCW), .MAX(OW-1)) u_xx (.clk(clk), .xrst(xrst), .clear(idle), .en(adv && xm && ym), .q(X), .at_max(xxm));
  wrap_cnt #(.W(OCW), .MAX(OW-1)) u_yy (.clk(clk), .xrst(xrst), .clear(idle), .en(adv && xm && ym && xxm), .q(Y), .at_max(yym));
  // w_load trails w_ren by one cycle; RUN starts once the last capture is done
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      state <= IDLE;
      w_ren <= 1'b0;
      w_load <= 1'b0;
      w_raddr <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          w_ren <= 1'b1;
          w_raddr <= '0;
        end
        LOAD: begin
          w_load <= w_ren;
          if (w_ren && w_raddr == AW'(NTAP-1)) w_ren <= 1'b0;
          else if (w_ren) w_raddr <= w_raddr + AW'(1);
          if (w_load && !w_ren) begin
            state <= RUN;
            w_raddr <= '0;
          end
        end
        RUN: if (adv && last) state <= DONE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scenario table plus random stalls, every cycle checked
// against a step-index model (counters derived by div/mod of the step count).
module tb_conv_seq_ctrl;
  import conv_pkg::*;
  localparam int TOT = KW*KW*OW*OW;
  localparam int LAT = 1 + NTAP + TOT + 1;
  logic clk = 1'b0, xrst = 1'b0, start = 1'b0, stall = 1'b0;
  logic [AW-1:0] w_raddr;
  logic w_ren, w_load, shift_x, shift_y, ret, valid, busy, finish;
  logic [KCW-1:0] x, y;
  logic [OCW-1:0] X, Y;
  conv_seq_ctrl dut (.clk(clk), .xrst(xrst), .start(start), .stall(stall), .w_raddr(w_raddr),
    .w_ren(w_ren), .w_load(w_load), .shift_x(shift_x), .shift_y(shift_y), .ret(ret),
    .x(x), .y(y), .X(X), .Y(Y), .valid(valid), .busy(busy), .finish(finish));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int mode = 0, li = 0, n = 0;
  int cyc, nvalid, last_xx, last_yy, fin_cyc, sx, sy, rt, stalls;
  typedef struct {
    string name;
    int stall_at, stall_len, start_at, rst_at, rnd, exp_lat, exp_valid;
  } scen_t;
  scen_t tbl[7];

  task automatic cmp(string nm, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check();
    logic [21:0] e, a;
    int ex, ey, exx, eyy;
    logic ev;
    if (!xrst) begin mode = 0; li = 0; n = 0; end
    ev = mode == 2 && !stall;
    ex = mode == 2 ? n % KW : 0;
    ey = mode == 2 ? (n / KW) % KW : 0;
    exx = mode == 2 ? (n / (KW*KW)) % OW : 0;
    eyy = mode == 2 ? n / (KW*KW*OW) : 0;
    e = {mode == 1 && li < NTAP, mode == 1 && li > 0, ev && ex < KW-1, ev && ex == KW-1 && ey < KW-1,
         ev && ex == KW-1 && ey == KW-1 && n < TOT-1, ev, mode == 1 || mode == 2, mode == 3,
         KCW'(ex), KCW'(ey), OCW'(exx), OCW'(eyy)};
    a = {w_ren, w_load, shift_x, shift_y, ret, valid, busy, finish, x, y, X, Y};
    tests++;
    if (a !== e) begin
      fails++;
      if (fails <= 20) $display("FAIL outputs cyc %0d mode %0d step %0d got %h expected %h", cyc, mode, n, a, e);
    end
    if (!xrst || (mode == 1 && li < NTAP)) begin
      tests++;
      if (w_raddr !== AW'(xrst ? li : 0)) begin
        fails++;
        if (fails <= 20) $display("FAIL w_raddr cyc %0d got %0d expected %0d", cyc, w_raddr, xrst ? li : 0);
      end
    end
    if (valid === 1'b1) begin
      if (nvalid < KW*KW) begin
        sx += int'(shift_x);
        sy += int'(shift_y);
        if (ret === 1'b1) rt = nvalid + 1;
      end
      nvalid++;
      last_xx = int'(X);
      last_yy = int'(Y);
    end
    if (finish === 1'b1 && fin_cyc < 0) fin_cyc = cyc;
  endtask

  task automatic advance();
    if (!xrst) mode = 0;
    else
      case (mode)
        0: if (start) begin mode = 1; li = 0; end
        1: if (li == NTAP) begin mode = 2; n = 0; end else li++;
        2: if (!stall) begin n++; if (n == TOT) mode = 3; end
        default: mode = 0;
      endcase
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    advance();
    cyc++;
    #1;
  endtask

  task automatic run(input int i);
    int held, exp;
    bit started, aborted;
    held = 0; started = 0; aborted = 0;
    nvalid = 0; fin_cyc = -1; sx = 0; sy = 0; rt = 0; stalls = 0; cyc = 0;
    stall = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 5000 && fin_cyc < 0 && !aborted) begin
      if (tbl[i].rnd != 0) stall = ($urandom % 6) == 0;
      else begin
        stall = mode == 2 && n == tbl[i].stall_at && held < tbl[i].stall_len;
        if (stall) held++;
      end
      start = mode == 2 && n == tbl[i].start_at && !started;
      if (start) started = 1;
      if (mode == 2 && n == tbl[i].rst_at) begin
        xrst = 1'b0;
        tick();
        tick();
        xrst = 1'b1;
        aborted = 1;
      end else begin
        if (mode == 2 && stall) stalls++;
        tick();
      end
    end
    stall = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    if (tbl[i].exp_lat < 0) begin
      cmp({tbl[i].name, " no_finish"}, fin_cyc, -1);
      return;
    end
    exp = tbl[i].rnd != 0 ? LAT + stalls : tbl[i].exp_lat;
    cmp({tbl[i].name, " latency"}, fin_cyc, exp);
    cmp({tbl[i].name, " valid_count"}, nvalid, tbl[i].exp_valid);
    cmp({tbl[i].name, " last_X"}, last_xx, OW-1);
    cmp({tbl[i].name, " last_Y"}, last_yy, OW-1);
    if (i == 0) begin
      cmp("window shift_x", sx, 6);
      cmp("window shift_y", sy, 2);
      cmp("window ret_step", rt, 9);
    end
  endtask

  initial begin
    tbl[0] = '{"plain", -1, 0, -1, -1, 0, 3267, 3249};
    tbl[1] = '{"stall5", 70, 5, -1, -1, 0, 3272, 3249};
    tbl[2] = '{"start_in_run", -1, 0, 500, -1, 0, 3267, 3249};
    tbl[3] = '{"reset_at_X10", -1, 0, -1, 90, 0, -1, -1};
    tbl[4] = '{"after_reset", -1, 0, -1, -1, 0, 3267, 3249};
    tbl[5] = '{"random_a", -1, 0, -1, -1, 1, 0, 3249};
    tbl[6] = '{"random_b", -1, 0, 1000, -1, 1, 0, 3249};
    cyc = 0;
    for (int k = 0; k < 3; k++) tick();
    xrst = 1'b1;
    for (int k = 0; k < 2; k++) tick();
    for (int i = 0; i < 7; i++) run(i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter KW, default 3: kernel window size per axis; x, y count 0..KW-1.
REQ-002 SHALL have parameter OW, default 19: output positions per axis; X, Y count 0..OW-1.
REQ-003 SHALL have parameter NTAP, default 16: weight words loaded per kernel fetch; address width 4.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port xrst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins one full scan.
REQ-007 SHALL have port stall, input, 1 bit: downstream not ready; freezes the scan.
REQ-008 SHALL have port w_raddr, output, 4 bits: weight memory read address.
REQ-009 SHALL have port w_ren, output, 1 bit: weight memory read enable.
REQ-010 SHALL have port w_load, output, 1 bit: capture strobe for weight registers.
REQ-011 SHALL have ports shift_x, shift_y and ret, outputs, 1 bit each: weight-tile move pulses for right, down and back-to-origin.
REQ-012 SHALL have ports x, y, outputs, 2 bits each: kernel position.
REQ-013 SHALL have ports X, Y, outputs, 5 bits each: output position.
REQ-014 SHALL have port valid, output, 1 bit: current (x,y,X,Y) is a live MAC step.
REQ-015 SHALL have ports busy and finish, outputs, 1 bit each: scan in progress; one-cycle scan-complete pulse.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-017 In IDLE, start=1 SHALL move to LOAD next cycle; start is ignored in every other state.
REQ-018 In LOAD, SHALL assert w_ren for NTAP consecutive cycles with w_raddr = 0..NTAP-1.
REQ-019 w_load SHALL follow each w_ren by exactly 1 cycle (1-cycle memory latency).
REQ-020 SHALL enter RUN the cycle after the last w_load; stall is ignored in LOAD.
REQ-021 In RUN with stall=0, SHALL assert valid and advance the counters: x fastest, then y, then X, then Y.
REQ-022 Each counter SHALL wrap to 0 at max and carry to the next counter.
REQ-023 In RUN with stall=1, SHALL hold all counters, drive valid=0 and suppress all shift/ret pulses.
REQ-024 On an advancing cycle, shift_x SHALL pulse when x increments without wrapping.
REQ-025 On an advancing cycle, shift_y SHALL pulse when x wraps and y increments.
REQ-026 On an advancing cycle, ret SHALL pulse when x and y both wrap; at most one of the three pulses is high per cycle.
REQ-027 The advancing cycle at x=y=KW-1, X=Y=OW-1 SHALL be the final valid step; the FSM then enters DONE with no ret pulse.
REQ-028 DONE SHALL last 1 cycle with finish=1, then return to IDLE with all counters at 0.
REQ-029 busy SHALL be 1 in LOAD and RUN, 0 in IDLE and DONE.
REQ-030 With no stalls, one scan SHALL be 1 + NTAP + KW*KW*OW*OW + 1 cycles from the start pulse to finish (default: 3267).

Reset
REQ-031 While xrst=0, the FSM SHALL be in IDLE.
REQ-032 While xrst=0, all counters and w_raddr SHALL be 0, and all strobes, valid, busy and finish SHALL be 0.
REQ-033 Reset mid-LOAD or mid-RUN SHALL abort the scan with no finish pulse; a new start is required afterwards.

Structure
REQ-034 SHALL place KW, OW, NTAP, the counter widths and the FSM state encoding in shared package conv_pkg.
REQ-035 SHALL build the counters from one sub-module, wrap_cnt (inputs clear and enable, parameter MAX; outputs q and max flag), instantiated four times.

Verification
REQ-036 Reset, then a start pulse -> w_ren high 16 cycles with w_raddr 0..15, w_load lagging by 1 cycle, then valid begins.
REQ-037 Full scan without stall -> finish exactly 3267 cycles after start, 3249 valid cycles, and (X,Y)=(18,18) on the last valid.
REQ-038 First window -> shift_x at x 0->1 and 1->2, shift_y at y 0->1 and 1->2, ret on the 9th valid step.
REQ-039 stall high for 5 cycles at x=1,y=2,X=7 -> counters hold, valid=0, no pulses; resume at the same point and total latency grows by 5.
REQ-040 start pulsed during RUN -> ignored, and finish timing is unchanged.
REQ-041 xrst low at X=10 in RUN -> all outputs 0 and state IDLE; after release, a new start produces a full, correct scan.
